scan_chain_ctrl: RTL
====================

Name: scan_chain_ctrl

Overview:
- Drives one scan chain built from the team's mux-D scan flops (sel = scan enable, in1 = scan data in).
- Per test, it loads a parallel pattern serially into the chain and pulses one functional capture cycle. It then unloads the chain serially and presents the captured word on a valid/ready handshake.
- Sits between the test sequencer, which supplies patterns, and the chain: scan_en to every flop's sel, scan_in to the head flop, scan_out from the tail.

Parameters:
- CHAIN_LEN, 8, number of scan flops in the chain (>= 2).
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width. Derived localparam; do not override.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  request a test; sampled only in IDLE.
- pattern_in  input  CHAIN_LEN  pattern; bit k is destined for chain flop k (flop 0 = head).
- busy  output  1  high in every state except IDLE.
- scan_en  output  1  drives sel of all chain flops.
- scan_in  output  1  serial data to the head flop's in1.
- scan_out  input  1  Q of the tail flop (flop CHAIN_LEN-1).
- response  output  CHAIN_LEN  captured chain contents; bit k = flop k after capture.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.

Behaviour:
- Reset (reset_n=0 at posedge) returns to IDLE from any state, including mid-shift. Reset values: state=IDLE, counter=0, scan_en=0, scan_in=0, busy=0, resp_valid=0, response=0, internal pattern register=0.
- All outputs are registered, or decoded directly from state plus registers. No input-to-output combinational path.
- IDLE:
  - scan_en=0, scan_in=0.
  - On start=1, latch pattern_in into pat_sr, clear the counter and go to SHIFT_IN.
- SHIFT_IN:
  - scan_en=1; scan_in = pat_sr[CHAIN_LEN-1] (MSB first).
  - Each cycle, pat_sr shifts left with 0 fill and the counter increments.
  - After exactly CHAIN_LEN cycles, flop k holds pattern_in[k]; go to CAPTURE.
- CAPTURE:
  - Exactly 1 cycle; scan_en=0, scan_in=0.
  - The chain flops load their functional D. Then clear the counter and go to SHIFT_OUT.
- SHIFT_OUT:
  - scan_en=1, scan_in=0 (chain fills with zeros).
  - Each cycle, at the same posedge the chain shifts: response <= {response[CHAIN_LEN-2:0], scan_out}.
  - After CHAIN_LEN cycles, response[k] = value captured in flop k; go to DONE.
- DONE:
  - scan_en=0, resp_valid=1. response is held stable while resp_valid=1.
  - When resp_valid && resp_ready at a posedge, resp_valid=0 and the state goes to IDLE. A start in the same cycle is ignored.
- start is ignored in every state except IDLE. pattern_in changes after the latch do not affect the test in progress.
- Latency: start-accept edge to resp_valid high = 2*CHAIN_LEN+1 cycles. Back-to-back minimum period = 2*CHAIN_LEN+3 cycles.
- Counter saturation: compare against CHAIN_LEN-1 for the state exit; the counter never wraps.

Optional Feature:
- Macro: SCAN_CHAIN_CTRL_COMPARE_EN.
- Defined:
  - Adds input expected_in [CHAIN_LEN] (latched with pattern_in on start) and output mismatch [1].
  - mismatch = |(response ^ expected_reg); registered on entry to DONE, valid while resp_valid=1, 0 otherwise and at reset.
- Undefined: neither port nor register exists. All other behaviour is identical.

Decomposition:
- Shared package scan_pkg holds:
  - state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE), 3-bit encoding;
  - default CHAIN_LEN constant;
  - fill-bit constant SCAN_FILL=0.
- One natural sub-module: scan_shift_reg. It is a CHAIN_LEN-bit parallel-load / serial-shift register with load, shift, serial-in and serial-out. It is instantiated twice: once as pattern source, once as response collector.
- The FSM and counter stay in the top.

Test Plan:
All scenarios use CHAIN_LEN=8. The bench models an 8-flop mux-D scan chain whose functional D of flop k = ~Q[k].
- Reset then idle: assert reset_n=0 for 2 cycles, then wait 10 cycles with no start. Required: scan_en=0, busy=0, resp_valid=0, response=0 throughout.
- Basic test: pattern_in=8'hA5, start pulse.
  - scan_en=1 for 8 cycles, 0 for 1, 1 for 8.
  - resp_valid rises 17 cycles after the accept edge with response=8'h5A; resp_ready=1 then gives IDLE next cycle.
- Backpressure: 8'h0F with resp_ready=0 for 20 cycles. Required: resp_valid and response=8'hF0 stay stable, busy=1, and start pulses are ignored; then resp_ready=1 returns to IDLE.
- Reset mid-shift: start 8'hFF, assert reset_n=0 in the 4th SHIFT_IN cycle. Required: next cycle IDLE with scan_en=0 and scan_in=0; a new start 8'h00 then yields response=8'hFF.
- Start ignored while busy: a second start with 8'h33 during SHIFT_OUT. Required: the first response completes unaffected and no second test runs.
- COMPARE_EN build: expected_in=8'h5A with pattern 8'hA5 must give mismatch=0; expected_in=8'h5B must give mismatch=1.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and constants for the scan chain controller.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int   DEF_CHAIN_LEN = 8;
    localparam logic SCAN_FILL     = 1'b0;

endpackage

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: parallel-load / serial-shift register; shifts toward the MSB, MSB is serial_out.
module scan_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    input  logic         serial_in,
    output logic [W-1:0] q,
    output logic         serial_out
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= {q[W-2:0], serial_in};
    end

    assign serial_out = q[W-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into a mux-D scan chain, pulses one capture, unloads the response.
// Define SCAN_CHAIN_CTRL_COMPARE_EN to add expected_in and a registered mismatch flag.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] expected_in,
    output logic                 mismatch,
`endif
    output logic                 busy,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic                 pat_msb;
    logic                 resp_msb;
    logic                 accept;
    logic                 last;
    logic                 unused;

    assign accept  = (state == IDLE) && start;
    assign last    = cnt == CNT_W'(CHAIN_LEN - 1);
    assign scan_in = (state == SHIFT_IN) && pat_msb;
    assign unused  = ^{pat_q, resp_msb};

    scan_shift_reg #(.W(CHAIN_LEN)) u_pattern (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .shift      (state == SHIFT_IN),
        .load_val   (pattern_in),
        .serial_in  (SCAN_FILL),
        .q          (pat_q),
        .serial_out (pat_msb)
    );

    // Collects the tail bit on the same edge the chain shifts, so flop k lands in bit k.
    scan_shift_reg #(.W(CHAIN_LEN)) u_response (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (1'b0),
        .shift      (state == SHIFT_OUT),
        .load_val   ('0),
        .serial_in  (scan_out),
        .q          (response),
        .serial_out (resp_msb)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_en    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        state   <= SHIFT_IN;
                        cnt     <= '0;
                        scan_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                SHIFT_IN:
                    if (last) begin
                        state   <= CAPTURE;
                        scan_en <= 1'b0;
                    end else
                        cnt <= cnt + 1'b1;
                CAPTURE: begin
                    state   <= SHIFT_OUT;
                    cnt     <= '0;
                    scan_en <= 1'b1;
                end
                SHIFT_OUT:
                    if (last) begin
                        state      <= DONE;
                        scan_en    <= 1'b0;
                        resp_valid <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                DONE:
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                default: begin
                    state      <= IDLE;
                    scan_en    <= 1'b0;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] resp_next;

    // Compare against the value the response register takes on the DONE-entry edge.
    assign resp_next = {response[CHAIN_LEN-2:0], scan_out};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_q    <= '0;
            mismatch <= 1'b0;
        end else begin
            if (accept)
                exp_q <= expected_in;
            if (state == SHIFT_OUT && last)
                mismatch <= |(resp_next ^ exp_q);
            else if (state == DONE && resp_ready)
                mismatch <= 1'b0;
        end
    end
`endif

endmodule
